// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC source codes and
// default vector/increment constants.
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_JMP  = 3'd2,
        NPC_CALL = 3'd3,
        NPC_RET  = 3'd4,
        NPC_EXC  = 3'd5
    } npc_src_e;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;
    localparam int          DEF_INC        = 4;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop of an empty stack is ignored, flush clears the occupancy count.
module ras_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW:0]      cnt;
    logic             do_pop, do_push;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign top     = mem[ptr];
    assign do_pop  = !flush && pop && !empty;
    assign do_push = !flush && !pop && push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (flush) begin
            ptr <= '0;
            cnt <= '0;
        end else if (do_pop) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end else if (do_push) begin
            ptr <= ptr + 1'b1;
            if (!full) cnt <= cnt + 1'b1;
        end
    end

    // Entry storage carries no reset; contents are only read when cnt > 0.
    always_ff @(posedge clk) begin
        if (do_push) mem[ptr + 1'b1] <= push_data;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: priority-selects the next fetch address and keeps a
// small return-address stack that predicts jr $ra targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int               INC          = DEF_INC,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             exc_req,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic             call,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             misaligned
);
    npc_src_e         src;
    logic             advance;
    logic [WIDTH-1:0] npc, ras_top;

    assign pc_plus_inc = pc_out + WIDTH'(INC);
    assign misaligned  = (pc_out[1:0] != 2'b00);
    // An exception still redirects while stalled; everything else freezes.
    assign advance     = exc_req || !stall;

    always_comb begin
        src = NPC_SEQ;
        if (exc_req)       src = NPC_EXC;
        else if (ret)      src = NPC_RET;
        else if (call)     src = NPC_CALL;
        else if (jmp)      src = NPC_JMP;
        else if (br_taken) src = NPC_BR;
    end

    always_comb begin
        npc = pc_plus_inc;
        case (src)
            NPC_BR:           npc = br_target;
            NPC_JMP, NPC_CALL: npc = jmp_target;
            NPC_RET:          npc = ras_empty ? ret_target : ras_top;
            NPC_EXC:          npc = EXC_VECTOR;
            default:          npc = pc_plus_inc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pc_out <= RESET_VECTOR;
        else if (advance) pc_out <= npc;
    end

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (advance && src == NPC_CALL),
        .pop       (advance && src == NPC_RET),
        .flush     (exc_req),
        .push_data (pc_plus_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized control traffic, all
// checked against a queue-based reference model of the PC and return stack.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, exc_req = 1'b0, br_taken = 1'b0, jmp = 1'b0;
    logic        call = 1'b0, ret = 1'b0;
    logic [31:0] br_target = '0, jmp_target = '0, ret_target = '0;
    logic [31:0] pc_out, pc_plus_inc;
    logic        ras_empty, ras_full, misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .call(call),
        .jmp_target(jmp_target), .ret(ret), .ret_target(ret_target),
        .pc_out(pc_out), .pc_plus_inc(pc_plus_inc), .ras_empty(ras_empty),
        .ras_full(ras_full), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("pc_out", pc_out, m_pc);
        chk("pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
        chk("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == 4});
        chk("misaligned", {31'd0, misaligned}, {31'd0, m_pc[1:0] != 2'b00});
    endtask

    // Reference behaviour of one rising edge given the currently driven inputs.
    task automatic model_edge();
        if (exc_req) begin
            m_pc = 32'h8000_0180;
            m_ras.delete();
        end else if (!stall) begin
            if (ret) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                else                  m_pc = ret_target;
            end else if (call) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
                m_pc = jmp_target;
            end else if (jmp)      m_pc = jmp_target;
            else if (br_taken)     m_pc = br_target;
            else                   m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic cyc(input logic st, input logic ex, input logic br, input logic j,
                       input logic c, input logic r, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] rt);
        stall = st; exc_req = ex; br_taken = br; jmp = j; call = c; ret = r;
        br_target = bt; jmp_target = jt; ret_target = rt;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic jump_to(input logic [31:0] t);
        cyc(0, 0, 0, 1, 0, 0, 32'h0, t, 32'h0);
    endtask

    // Asynchronous reset: outputs must change before any clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        m_pc = 32'h0;
        m_ras.delete();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] held, t1, t2;
        logic        st, ex, br, j, c, r;
        do_reset();
        chk("reset_pc", pc_out, 32'h0);

        idle(); chk("seq_4", pc_out, 32'h4);
        idle(); chk("seq_8", pc_out, 32'h8);
        idle(); idle(); chk("seq_10", pc_out, 32'h10);
        do_reset(); chk("midrun_reset", pc_out, 32'h0);

        held = pc_out;
        cyc(1, 0, 1, 0, 0, 0, 32'h40, 32'h0, 32'h0); chk("stall_br", pc_out, held);
        cyc(0, 0, 0, 0, 1, 0, 32'h0, 32'h20, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        chk("exc_stall", pc_out, 32'h8000_0180);
        chk("exc_flush", {31'd0, ras_empty}, 32'd1);
        cyc(0, 0, 1, 1, 0, 0, 32'h40, 32'h100, 32'h0); chk("jmp_over_br", pc_out, 32'h100);

        jump_to(32'h20);
        cyc(0, 0, 0, 0, 1, 0, 32'h0, 32'h200, 32'h0); chk("call_pc", pc_out, 32'h200);
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h999); chk("ret_pc", pc_out, 32'h24);
        chk("ret_empty", {31'd0, ras_empty}, 32'd1);
        cyc(0, 0, 0, 0, 1, 1, 32'h0, 32'h500, 32'h300); chk("call_ret", pc_out, 32'h300);
        chk("call_ret_nopush", {31'd0, ras_empty}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            jump_to(32'(i) * 32'h100);
            cyc(0, 0, 0, 0, 1, 0, 32'h0, 32'h1000, 32'h0);
        end
        chk("ovf_full", {31'd0, ras_full}, 32'd1);
        for (int i = 4; i >= 1; i--) begin
            cyc(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h55c);
            chk("ovf_pop", pc_out, 32'(i) * 32'h100 + 32'h4);
        end
        cyc(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h55c); chk("ovf_pop5", pc_out, 32'h55c);

        jump_to(32'hFFFF_FFFC);
        idle(); chk("wrap", pc_out, 32'h0);
        jump_to(32'h102); chk("misaligned", {31'd0, misaligned}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                ex = ($urandom_range(0, 29) == 0);
                st = ($urandom_range(0, 5) == 0);
                r  = ($urandom_range(0, 4) == 0);
                c  = ($urandom_range(0, 3) == 0);
                j  = ($urandom_range(0, 7) == 0);
                br = ($urandom_range(0, 3) == 0);
                t1 = $urandom;
                t2 = $urandom;
                if ($urandom_range(0, 9) != 0) begin
                    t1[1:0] = 2'b00;
                    t2[1:0] = 2'b00;
                end
                cyc(st, ex, br, j, c, r, t1, t2, $urandom & 32'hFFFF_FFFC);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
